// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, address bit positions and refresh FSM states.
package sdram_pkg;

   // {CSn, RASn, CASn, WEn}
   localparam logic [3:0] CMD_NOP          = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
   localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
   localparam logic [3:0] CMD_MODE_REG_SET = 4'b0000;

   localparam int unsigned A10_BIT = 10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRE      = 3'd1,
      ST_WAIT_RP  = 3'd2,
      ST_REF      = 3'd3,
      ST_WAIT_RFC = 3'd4,
      ST_DONE     = 3'd5
   } ref_state_t;

endpackage

// File: rtl/sdram_refresh_sched_if.sv
// Arbiter-facing handshake and command bus of the refresh scheduler.
interface sdram_refresh_sched_if #(
   parameter int unsigned ADDR_W = 13
);
   logic              ref_grant;
   logic              ref_req;
   logic              ref_urgent;
   logic              ref_busy;
   logic              ref_done;
   logic [3:0]        sdram_cmd;
   logic [ADDR_W-1:0] sdram_addr;
   logic [3:0]        debt;
   logic              overflow_err;

   modport master (
      input  ref_grant,
      output ref_req, ref_urgent, ref_busy, ref_done,
      output sdram_cmd, sdram_addr, debt, overflow_err
   );

   modport slave (
      output ref_grant,
      input  ref_req, ref_urgent, ref_busy, ref_done,
      input  sdram_cmd, sdram_addr, debt, overflow_err
   );
endinterface

// File: rtl/sdram_refi_timer.sv
// Refresh interval counter: one-cycle tick every TREFI_CYC cycles while enabled.
module sdram_refi_timer #(
   parameter int unsigned TREFI_CYC = 390
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);
   localparam int unsigned CNT_W = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TREFI_CYC - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!en || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler: refresh debt accounting, arbiter request and
// PRECHARGE ALL / AUTO REFRESH sequencing with tRP/tRFC spacing.
module sdram_refresh_sched
   import sdram_pkg::*;
#(
   parameter int unsigned CLK_FREQ_MHZ  = 50,
   parameter int unsigned TREFI_NS      = 7800,
   parameter int unsigned TRP_CYC       = 2,
   parameter int unsigned TRFC_CYC      = 7,
   parameter int unsigned MAX_DEBT      = 8,
   parameter int unsigned URGENT_THRESH = 6,
   parameter bit          DRAIN_ALL     = 1'b1,
   parameter int unsigned ADDR_W        = 13
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   init_done,
   sdram_refresh_sched_if.master  sched
);
   localparam int unsigned TREFI_CYC = CLK_FREQ_MHZ * TREFI_NS / 1000;
   localparam int unsigned WAIT_MAX  = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
   localparam int unsigned WAIT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [3:0]  MAX_D     = 4'(MAX_DEBT);
   localparam logic [3:0]  URG_D     = 4'(URGENT_THRESH);
   localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(1) << A10_BIT;

   ref_state_t        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [3:0]        debt_q, debt_d;
   logic              tick;
   logic              issue;
   logic              drain_more;

   sdram_refi_timer #(
      .TREFI_CYC (TREFI_CYC)
   ) u_refi_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (init_done),
      .tick  (tick)
   );

   // debt_q already reflects the decrement of the refresh just issued
   assign drain_more = DRAIN_ALL && (debt_q != '0);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            if (sched.ref_grant && debt_q != '0) state_d = ST_PRE;
         end
         ST_PRE: begin
            if (TRP_CYC > 1) begin
               state_d = ST_WAIT_RP;
               wait_d  = WAIT_W'(TRP_CYC - 2);
            end else begin
               state_d = ST_REF;
            end
         end
         ST_WAIT_RP: begin
            if (wait_q == '0) state_d = ST_REF;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         ST_REF: begin
            if (TRFC_CYC > 1) begin
               state_d = ST_WAIT_RFC;
               wait_d  = WAIT_W'(TRFC_CYC - 2);
            end else begin
               state_d = drain_more ? ST_REF : ST_DONE;
            end
         end
         ST_WAIT_RFC: begin
            if (wait_q == '0) state_d = drain_more ? ST_REF : ST_DONE;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A refresh is issued on the edge that enters REF, so the decrement lands
   // together with the AUTO REFRESH command on the bus.
   assign issue = (state_d == ST_REF);

   always_comb begin
      debt_d = debt_q;
      case ({tick, issue})
         2'b10:   debt_d = (debt_q == MAX_D) ? debt_q : debt_q + 4'd1;
         2'b01:   debt_d = debt_q - 4'd1;
         default: debt_d = debt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= ST_IDLE;
         wait_q             <= '0;
         debt_q             <= '0;
         sched.sdram_cmd    <= CMD_NOP;
         sched.sdram_addr   <= '0;
         sched.ref_req      <= 1'b0;
         sched.ref_urgent   <= 1'b0;
         sched.ref_busy     <= 1'b0;
         sched.ref_done     <= 1'b0;
         sched.overflow_err <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         debt_q  <= debt_d;
         case (state_d)
            ST_PRE:  sched.sdram_cmd <= CMD_PRECHARGE;
            ST_REF:  sched.sdram_cmd <= CMD_AUTO_REFRESH;
            default: sched.sdram_cmd <= CMD_NOP;
         endcase
         sched.sdram_addr <= (state_d == ST_PRE) ? PRE_ADDR : '0;
         sched.ref_busy   <= (state_d != ST_IDLE);
         sched.ref_done   <= (state_d == ST_DONE);
         sched.ref_req    <= (state_d == ST_IDLE) && (debt_q != '0);
         sched.ref_urgent <= (debt_q >= URG_D);
         if (tick && debt_q == MAX_D) sched.overflow_err <= 1'b1;
      end
   end

   assign sched.debt = debt_q;

endmodule
